fetch_unit: RTL and testbench

Instruction fetch stage for REDUX-V. It sits directly upstream of control_unit.
- Holds the PC and drives a request/ready handshake to instruction memory.
- Captures the returned word in an instruction register.
- Presents op/ra/rb to decode.
- Applies branch (BRZR) and jump (JI) redirects when decode consumes the instruction.

---
 rtl/redux_pkg.sv | 44 ++++
 rtl/fetch_pc.sv | 36 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/redux_pkg.sv
// Shared REDUX-V definitions: opcodes, control-word indices, instruction field layout and
// the fetch state encoding.
package redux_pkg;

  localparam logic [3:0] BRZR = 4'h0;
  localparam logic [3:0] JI   = 4'h1;
  localparam logic [3:0] LD   = 4'h2;
  localparam logic [3:0] ST   = 4'h3;
  localparam logic [3:0] ADDI = 4'h4;
  localparam logic [3:0] PUSH = 4'h5;
  localparam logic [3:0] POP  = 4'h6;
  localparam logic [3:0] MOV  = 4'h7;
  localparam logic [3:0] NOT  = 4'h8;
  localparam logic [3:0] AND  = 4'h9;
  localparam logic [3:0] OR   = 4'hA;
  localparam logic [3:0] XOR  = 4'hB;
  localparam logic [3:0] ADD  = 4'hC;
  localparam logic [3:0] SUB  = 4'hD;
  localparam logic [3:0] SLR  = 4'hE;
  localparam logic [3:0] SRR  = 4'hF;

  localparam int unsigned BR     = 0;
  localparam int unsigned J      = 1;
  localparam int unsigned RA     = 2;
  localparam int unsigned RE     = 3;
  localparam int unsigned DM     = 4;
  localparam int unsigned WE     = 5;
  localparam int unsigned SE     = 6;
  localparam int unsigned CTRL_W = 7;

  localparam int unsigned ALU_OP_W = 3;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 2;
  localparam int unsigned OP_LSB = 4;
  localparam int unsigned RA_LSB = 2;
  localparam int unsigned RB_LSB = 0;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with next-PC mux; advances (or redirects) only when load_i is asserted.
module fetch_pc
  import redux_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Increment wraps modulo 2^PC_W by construction.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = redirect_i ? target_i : pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// REDUX-V fetch stage: two-state fetch/issue FSM feeding decode.
// Optional perf counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_unit
  import redux_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 8,
  parameter int unsigned     OP       = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               j_taken,
  input  logic [PC_W-1:0]    target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [OP-1:0]      op,
  output logic [REG_W-1:0]   ra,
  output logic [REG_W-1:0]   rb,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall,
`endif
  output logic [PC_W-1:0]    pc_out
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc;
  logic                pc_load;
  logic                fetch_done;
  logic [INSTR_W-1:0]  instr_q;
  logic [PC_W-1:0]     pc_out_q;

  fetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (pc_load),
    .redirect_i (br_taken | j_taken),
    .target_i   (target),
    .pc_o       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (imem_ready) state_d = ISSUE;
      ISSUE:   if (!stall)     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Gating with rst_n drops the request and valid without waiting for a clock edge.
  always_comb begin
    imem_req    = rst_n && (state_q == FETCH);
    instr_valid = rst_n && (state_q == ISSUE);
    fetch_done  = (state_q == FETCH) && imem_ready;
    pc_load     = (state_q == ISSUE) && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      pc_out_q <= RESET_PC;
    end else if (fetch_done) begin
      instr_q  <= imem_rdata;
      pc_out_q <= pc;
    end
  end

  assign imem_addr = pc;
  assign instr     = instr_q;
  assign pc_out    = pc_out_q;
  assign op        = instr_q[OP_LSB +: OP];
  assign ra        = instr_q[RA_LSB +: REG_W];
  assign rb        = instr_q[RB_LSB +: REG_W];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (fetch_done && (perf_fetched_q != 16'hFFFF)) perf_fetched_d = perf_fetched_q + 16'd1;
    if ((state_q == ISSUE) && stall && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ready;
  logic       stall;
  logic       br_taken;
  logic       j_taken;
  logic [7:0] target;
  logic       instr_valid;
  logic [7:0] instr;
  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "holding" flag, fetch pointer and the captured instruction.
  bit m_holding;
  int m_pc;
  int m_instr;
  int m_pc_out;
  int m_fetched;
  int m_stalls;

  fetch_unit #(
    .PC_W     (8),
    .INSTR_W  (8),
    .OP       (4),
    .RESET_PC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .br_taken    (br_taken),
    .j_taken     (j_taken),
    .target      (target),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .ra          (ra),
    .rb          (rb),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
`endif
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holding = 1'b0;
    m_pc      = 0;
    m_instr   = 0;
    m_pc_out  = 0;
    m_fetched = 0;
    m_stalls  = 0;
  endtask

  task automatic check_all();
    check_eq("imem_req",    {31'd0, imem_req},    {31'd0, (rst_n === 1'b1) && !m_holding});
    check_eq("imem_addr",   {24'd0, imem_addr},   m_pc);
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, (rst_n === 1'b1) && m_holding});
    check_eq("instr",       {24'd0, instr},       m_instr);
    check_eq("op",          {28'd0, op},          m_instr / 16);
    check_eq("ra",          {30'd0, ra},          (m_instr / 4) % 4);
    check_eq("rb",          {30'd0, rb},          m_instr % 4);
    check_eq("pc_out",      {24'd0, pc_out},      m_pc_out);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetched", {16'd0, perf_fetched}, m_fetched);
    check_eq("perf_stall",   {16'd0, perf_stall},   m_stalls);
`endif
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, check after.
  task automatic step(input bit rdy, input logic [7:0] rd, input bit st, input bit br,
                      input bit jt, input logic [7:0] tg);
    imem_ready = rdy;
    imem_rdata = rd;
    stall      = st;
    br_taken   = br;
    j_taken    = jt;
    target     = tg;
    @(posedge clk);
    if (!m_holding) begin
      if (rdy) begin
        m_instr   = rd;
        m_pc_out  = m_pc;
        m_holding = 1'b1;
        if (m_fetched < 65535) m_fetched++;
      end
    end else if (st) begin
      if (m_stalls < 65535) m_stalls++;
    end else begin
      m_pc      = (br || jt) ? int'(tg) : (m_pc + 1) % 256;
      m_holding = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  // Assert reset between edges, confirm the asynchronous drop, then release.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_req_drop"},   {31'd0, imem_req},    32'd0);
    check_eq({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq({tag, "_addr_reset"}, {24'd0, imem_addr}, 32'h00);
    check_all();
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 8'h00;
    stall      = 1'b0;
    br_taken   = 1'b0;
    j_taken    = 1'b0;
    target     = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("reset_req", {31'd0, imem_req}, 32'd1);
    check_all();

    // Back-to-back fetches with immediate ready.
    step(1, 8'h1A, 0, 0, 0, 8'h00);
    check_eq("i0_op", {28'd0, op}, 32'h1);
    check_eq("i0_ra", {30'd0, ra}, 32'd2);
    check_eq("i0_rb", {30'd0, rb}, 32'd2);
    check_eq("i0_pc", {24'd0, pc_out}, 32'h0);
    step(1, 8'hEE, 0, 0, 0, 8'h00);
    check_eq("i0_consumed", {31'd0, instr_valid}, 32'd0);
    step(1, 8'h25, 0, 0, 0, 8'h00);
    check_eq("i1_op", {28'd0, op}, 32'h2);
    check_eq("i1_ra", {30'd0, ra}, 32'd1);
    check_eq("i1_rb", {30'd0, rb}, 32'd1);
    check_eq("i1_pc", {24'd0, pc_out}, 32'h1);
    step(1, 8'h00, 0, 0, 0, 8'h00);
    repeat (2) begin
      step(1, 8'h33, 0, 0, 0, 8'h00);
      step(1, 8'h00, 0, 0, 0, 8'h00);
    end

    // Memory wait states at pc=4; rdata garbage must be ignored.
    repeat (3) begin
      step(0, 8'hC3, 0, 1, 1, 8'h77);
      check_eq("wait_addr", {24'd0, imem_addr}, 32'h04);
      check_eq("wait_req",  {31'd0, imem_req},  32'd1);
    end
    step(1, 8'h9C, 0, 0, 0, 8'h00);
    check_eq("wait_pc_out", {24'd0, pc_out}, 32'h04);

    // Stall with a branch pulse in the middle: redirect must be ignored.
    for (int i = 0; i < 5; i++) step(0, 8'h55, 1, (i == 2), 0, 8'h99);
    check_eq("stall_held", {24'd0, instr}, 32'h9C);
    step(0, 8'h55, 0, 0, 0, 8'h99);
    check_eq("stall_next_addr", {24'd0, imem_addr}, 32'h05);

    // Jump, branch+jump, and wrap past 0xFF.
    step(1, 8'h1F, 0, 0, 0, 8'h00);
    step(0, 8'h00, 0, 0, 1, 8'h40);
    check_eq("jump_addr", {24'd0, imem_addr}, 32'h40);
    step(1, 8'h0E, 0, 0, 0, 8'h00);
    step(0, 8'h00, 0, 1, 1, 8'h10);
    check_eq("brj_addr", {24'd0, imem_addr}, 32'h10);
    step(1, 8'h1D, 0, 0, 0, 8'h00);
    step(0, 8'h00, 0, 0, 1, 8'hFF);
    step(1, 8'h7B, 0, 0, 0, 8'h00);
    check_eq("ff_pc_out", {24'd0, pc_out}, 32'hFF);
    step(0, 8'h00, 0, 0, 0, 8'h12);
    check_eq("wrap_addr", {24'd0, imem_addr}, 32'h00);

    // Reset in the middle of a fetch and of an issue.
    step(0, 8'h00, 0, 0, 0, 8'h00);
    async_reset("rst_fetch");
    step(1, 8'hA6, 1, 0, 0, 8'h00);
    check_eq("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    async_reset("rst_issue");
    check_eq("rst_issue_instr", {24'd0, instr}, 32'h00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 3),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
